// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: drives buffer en/clr
// and PC enable for load-use, branch flush, mult/div occupancy and syscall halt.
module pipeline_ctrl #(
  parameter int unsigned MDU_CYCLES = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_R1_pos,
  input  logic [4:0]       id_R2_pos,
  input  logic             id_R1_use,
  input  logic             id_R2_use,
  input  logic [4:0]       ex_dst,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             wb_halt,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic             memwb_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MDU  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Entry cycle is the first stall, so the down-counter covers the remaining ones.
  localparam logic [7:0] MCNT_INIT = 8'(MDU_CYCLES - 2);

  state_t           state_q, state_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_inc;
  logic flush_inc;

  assign load_use = ex_memread && (ex_dst != 5'd0) &&
                    ((id_R1_use && (id_R1_pos == ex_dst)) ||
                     (id_R2_use && (id_R2_pos == ex_dst)));

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    exmem_clr = 1'b0;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (wb_halt) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          state_d  = S_HALT;
        end else if (ex_branch_taken) begin
          ifid_clr  = 1'b1;
          idex_clr  = 1'b1;
          flush_inc = 1'b1;
        end else if (ex_mdu_start) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_clr = 1'b1;
          stall_inc = 1'b1;
          mcnt_d    = MCNT_INIT;
          state_d   = S_MDU;
        end else if (load_use) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_clr  = 1'b1;
          stall_inc = 1'b1;
        end
      end
      S_MDU: begin
        if (wb_halt) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          mcnt_d   = '0;
          state_d  = S_HALT;
        end else if (mcnt_q != 8'd0) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_clr = 1'b1;
          stall_inc = 1'b1;
          mcnt_d    = mcnt_q - 8'd1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        if (go) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset holds every buffer enabled with clear so all stages fill with bubbles.
    if (rst) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b1;
      ifid_clr  = 1'b1;
      idex_en   = 1'b1;
      idex_clr  = 1'b1;
      exmem_en  = 1'b1;
      exmem_clr = 1'b1;
      memwb_en  = 1'b1;
      memwb_clr = 1'b1;
    end
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != S_HALT) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
    if (stall_inc) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_inc) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      mcnt_q      <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == S_HALT) && !rst;
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed table, hand-written multi-cycle
// sequences and random stimulus against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned MDU_C = 5;

  // Control vector order: pc, ifid_en, ifid_clr, idex_en, idex_clr,
  // exmem_en, exmem_clr, memwb_en, memwb_clr
  localparam logic [8:0] ADV    = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] FREEZE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] FLUSH  = 9'b1_1_1_1_1_1_0_1_0;
  localparam logic [8:0] MDUST  = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] LUST   = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] RSTV   = 9'b0_1_1_1_1_1_1_1_1;

  typedef struct {
    logic       rst;
    logic [4:0] r1p;
    logic       r1u;
    logic [4:0] r2p;
    logic       r2u;
    logic [4:0] dst;
    logic       mr;
    logic       br;
    logic       mdu;
    logic       halt;
    logic       go;
  } in_t;

  typedef struct {
    in_t         in;
    logic [8:0]  ctrl;
    int unsigned cyc;
    int unsigned stl;
    int unsigned fl;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_R1_pos, id_R2_pos, ex_dst;
  logic        id_R1_use, id_R2_use, ex_memread, ex_branch_taken, ex_mdu_start;
  logic        wb_halt, go;
  logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic        exmem_en, exmem_clr, memwb_en, memwb_clr, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [8:0]  dut_ctrl;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Behavioural model: halted flag, MDU occupancy as cycles elapsed since start.
  bit          m_halted = 1'b0;
  bit          m_in_mdu = 1'b0;
  int unsigned m_age    = 0;
  bit          m_known  = 1'b0;
  logic [31:0] m_cyc, m_stl, m_fl;

  vec_t tbl[11];

  pipeline_ctrl #(.MDU_CYCLES(MDU_C), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_R1_pos(id_R1_pos), .id_R2_pos(id_R2_pos),
    .id_R1_use(id_R1_use), .id_R2_use(id_R2_use),
    .ex_dst(ex_dst), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .wb_halt(wb_halt), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
    .idex_en(idex_en), .idex_clr(idex_clr),
    .exmem_en(exmem_en), .exmem_clr(exmem_clr),
    .memwb_en(memwb_en), .memwb_clr(memwb_clr),
    .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign dut_ctrl = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                     exmem_en, exmem_clr, memwb_en, memwb_clr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkin(logic r, logic [4:0] r1p, logic r1u, logic [4:0] r2p,
                               logic r2u, logic [4:0] dst, logic mr, logic br,
                               logic mdu, logic halt, logic g);
    in_t i;
    i.rst = r; i.r1p = r1p; i.r1u = r1u; i.r2p = r2p; i.r2u = r2u;
    i.dst = dst; i.mr = mr; i.br = br; i.mdu = mdu; i.halt = halt; i.go = g;
    return i;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t i);
    rst = i.rst; id_R1_pos = i.r1p; id_R1_use = i.r1u;
    id_R2_pos = i.r2p; id_R2_use = i.r2u; ex_dst = i.dst;
    ex_memread = i.mr; ex_branch_taken = i.br; ex_mdu_start = i.mdu;
    wb_halt = i.halt; go = i.go;
  endtask

  task automatic model_eval(input in_t i, output logic [8:0] c, output bit st, output bit fl);
    bit lu;
    lu = i.mr && (i.dst != 0) && ((i.r1u && i.r1p == i.dst) || (i.r2u && i.r2p == i.dst));
    st = 1'b0;
    fl = 1'b0;
    if (i.rst)                         c = RSTV;
    else if (m_halted || i.halt)       c = FREEZE;
    else if (m_in_mdu) begin
      if (m_age < MDU_C - 1) begin c = MDUST; st = 1'b1; end
      else                         c = ADV;
    end
    else if (i.br)                     begin c = FLUSH; fl = 1'b1; end
    else if (i.mdu)                    begin c = MDUST; st = 1'b1; end
    else if (lu)                       begin c = LUST;  st = 1'b1; end
    else                               c = ADV;
  endtask

  task automatic model_update(input in_t i, input bit st, input bit fl);
    if (i.rst) begin
      m_halted = 1'b0; m_in_mdu = 1'b0; m_age = 0; m_known = 1'b1;
      m_cyc = '0; m_stl = '0; m_fl = '0;
    end else begin
      if (!m_halted) m_cyc++;
      if (st) m_stl++;
      if (fl) m_fl++;
      if (m_halted) begin
        if (i.go) m_halted = 1'b0;
      end else if (i.halt) begin
        m_halted = 1'b1; m_in_mdu = 1'b0;
      end else if (m_in_mdu) begin
        if (m_age >= MDU_C - 1) m_in_mdu = 1'b0;
        else m_age++;
      end else if (!i.br && i.mdu) begin
        m_in_mdu = 1'b1; m_age = 1;
      end
    end
  endtask

  task automatic run_cycle(input in_t i, input string nm, input bit he, input logic [8:0] ec,
                           input bit hc, input int unsigned ecyc, input int unsigned estl,
                           input int unsigned efl);
    logic [8:0] mc;
    bit st, fl;
    apply(i);
    @(negedge clk);
    model_eval(i, mc, st, fl);
    chk({nm, ".ctrl"}, dut_ctrl, mc);
    if (he) chk({nm, ".ctrl_exp"}, dut_ctrl, ec);
    chk({nm, ".halted"}, halted, m_halted && !i.rst);
    if (m_known) begin
      chk({nm, ".cycle_cnt"}, cycle_cnt, m_cyc);
      chk({nm, ".stall_cnt"}, stall_cnt, m_stl);
      chk({nm, ".flush_cnt"}, flush_cnt, m_fl);
    end
    if (hc) begin
      chk({nm, ".cycle_exp"}, cycle_cnt, ecyc);
      chk({nm, ".stall_exp"}, stall_cnt, estl);
      chk({nm, ".flush_exp"}, flush_cnt, efl);
    end
    @(posedge clk);
    model_update(i, st, fl);
    #1;
  endtask

  initial begin
    in_t idle, r, lu;
    idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r    = mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{idle,                                         ADV,   0, 0, 0};
    tbl[1]  = '{mkin(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0),        LUST,  1, 0, 0};
    tbl[2]  = '{mkin(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0),        ADV,   2, 1, 0};
    tbl[3]  = '{mkin(0, 0, 0, 7, 1, 7, 1, 0, 0, 0, 0),        LUST,  3, 1, 0};
    tbl[4]  = '{mkin(0, 0, 0, 7, 0, 7, 1, 0, 0, 0, 0),        ADV,   4, 2, 0};
    tbl[5]  = '{mkin(0, 7, 1, 0, 0, 7, 0, 0, 0, 0, 0),        ADV,   5, 2, 0};
    tbl[6]  = '{mkin(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0),        FLUSH, 6, 2, 0};
    tbl[7]  = '{idle,                                         ADV,   7, 2, 1};
    tbl[8]  = '{mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),        FLUSH, 8, 2, 1};
    tbl[9]  = '{idle,                                         ADV,   9, 2, 2};
    tbl[10] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),        ADV,  10, 2, 2};

    // Reset: two cycles, counters defined after the first edge.
    run_cycle(r, "rst0", 1, RSTV, 0, 0, 0, 0);
    run_cycle(r, "rst1", 1, RSTV, 1, 0, 0, 0);

    for (int k = 0; k < 11; k++)
      run_cycle(tbl[k].in, $sformatf("tbl%0d", k), 1, tbl[k].ctrl, 1,
                tbl[k].cyc, tbl[k].stl, tbl[k].fl);

    // MDU held: 4 stalls then release; branch/load-use ignored while occupied.
    lu = mkin(0, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0);
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "mdu0", 1, MDUST, 1, 11, 2, 2);
    run_cycle(lu, "mdu1", 1, MDUST, 0, 0, 0, 0);
    run_cycle(lu, "mdu2", 1, MDUST, 0, 0, 0, 0);
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "mdu3", 1, MDUST, 0, 0, 0, 0);
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "mdu_rel", 1, ADV, 1, 15, 6, 2);
    run_cycle(idle, "mdu_after", 1, ADV, 1, 16, 6, 2);

    // Halt and resume.
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt", 1, FREEZE, 1, 17, 6, 2);
    for (int k = 0; k < 10; k++)
      run_cycle(idle, "halted", 1, FREEZE, 1, 18, 6, 2);
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "go", 1, FREEZE, 1, 18, 6, 2);
    run_cycle(idle, "resume0", 1, ADV, 1, 18, 6, 2);
    run_cycle(idle, "resume1", 1, ADV, 1, 19, 6, 2);

    // Halt during the second MDU stall; nothing of the MDU survives go.
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "hm_ent", 1, MDUST, 1, 20, 6, 2);
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "hm_halt", 1, FREEZE, 1, 21, 7, 2);
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "hm_go", 1, FREEZE, 1, 22, 7, 2);
    for (int k = 0; k < 4; k++)
      run_cycle(idle, "hm_after", 1, ADV, 1, 22 + k, 7, 2);

    // Reset during MDU.
    run_cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rm_ent", 1, MDUST, 1, 26, 7, 2);
    run_cycle(idle, "rm_stall", 1, MDUST, 1, 27, 8, 2);
    run_cycle(r, "rm_rst", 1, RSTV, 1, 28, 9, 2);
    run_cycle(idle, "rm_after0", 1, ADV, 1, 0, 0, 0);
    run_cycle(idle, "rm_after1", 1, ADV, 1, 1, 0, 0);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      in_t ri;
      ri.rst  = ($urandom_range(0, 99) == 0);
      ri.r1p  = 5'($urandom_range(0, 3));
      ri.r2p  = 5'($urandom_range(0, 3));
      ri.r1u  = 1'($urandom_range(0, 1));
      ri.r2u  = 1'($urandom_range(0, 1));
      ri.dst  = 5'($urandom_range(0, 3));
      ri.mr   = 1'($urandom_range(0, 1));
      ri.br   = ($urandom_range(0, 5) == 0);
      ri.mdu  = ($urandom_range(0, 7) == 0);
      ri.halt = ($urandom_range(0, 19) == 0);
      ri.go   = ($urandom_range(0, 3) == 0);
      run_cycle(ri, "rand", 0, '0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives the `en`/`clr` pair of each inter-stage buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves:
- load-use stalls;
- taken-branch flushes;
- multi-cycle multiply/divide occupancy of EX;
- program halt on syscall exit.

It also keeps cycle, stall and flush performance counters.

## Interface
Parameters:
- `MDU_CYCLES`, default 5: total cycles a mult/div instruction occupies EX; legal range 2..255.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `id_R1_pos`, `id_R2_pos`  in  5  source register numbers of the instruction in ID.
- `id_R1_use`, `id_R2_use`  in  1  the matching source is actually read.
- `ex_dst`  in  5  destination register of the instruction in EX.
- `ex_memread`  in  1  the instruction in EX is a load.
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX.
- `ex_mdu_start`  in  1  the instruction in EX is mult/div.
- `wb_halt`  in  1  syscall-exit instruction in WB.
- `go`  in  1  resume from halt.
- `pc_en`  out  1  PC write enable.
- `ifid_en`, `ifid_clr`, `idex_en`, `idex_clr`, `exmem_en`, `exmem_clr`, `memwb_en`, `memwb_clr`  out  1  buffer controls. `clr` only has effect with `en`=1, and inserts a bubble.
- `halted`  out  1  state is HALT.
- `cycle_cnt`, `stall_cnt`, `flush_cnt`  out  CNT_W  performance counters.

## Operation
- States: RUN, MDU, HALT. MDU holds a down-counter `mcnt` (8 bits).
- Default action is "advance": `pc_en`=1, all `en`=1, all `clr`=0.
- Control outputs are combinational from state and inputs. State, `mcnt` and counters are registered.

RUN, priority order (highest first):
1. **Halt:** `wb_halt` → `pc_en`=0, all `en`=0; next state HALT.
2. **Flush:** `ex_branch_taken` → advance, with `ifid_clr`=1 and `idex_clr`=1; `flush_cnt`+1. A flush overrides a simultaneous load-use.
3. **MDU entry:** `ex_mdu_start` →
   - `pc_en`=0, `ifid_en`=0, `idex_en`=0;
   - `exmem_en`=1, `exmem_clr`=1, `memwb_en`=1;
   - `stall_cnt`+1; `mcnt` ← MDU_CYCLES−2; next state MDU.
4. **Load-use:** `ex_memread` && `ex_dst`≠0 && ((`id_R1_use` && `id_R1_pos`==`ex_dst`) || (`id_R2_use` && `id_R2_pos`==`ex_dst`)) →
   - `pc_en`=0, `ifid_en`=0;
   - `idex_en`=1, `idex_clr`=1;
   - EX/MEM and MEM/WB advance; `stall_cnt`+1.
5. Otherwise advance.

MDU:
- `wb_halt` → same as RUN rule 1; `mcnt` is discarded.
- Else if `mcnt`≠0: same outputs as MDU entry; `stall_cnt`+1; `mcnt`−1.
- Else (`mcnt`==0): advance; next state RUN. `ex_mdu_start` is ignored in this release cycle.
- `ex_branch_taken` and load-use are ignored in MDU.

HALT:
- `pc_en`=0, all `en`=0; pipeline contents are frozen.
- `go` → next state RUN; outputs in that `go` cycle remain frozen.

Counters:
- `cycle_cnt` +1 every cycle in RUN or MDU, and frozen in HALT.
- All counters wrap modulo 2^CNT_W.

## Timing
- While `rst`=1: `pc_en`=0, all `en`=1, all `clr`=0... corrected: all `clr`=1, `halted`=0. This flushes every buffer to a bubble.
- First edge with `rst`=1: state ← RUN; `mcnt` and all counters ← 0.
- Reset mid-MDU or in HALT returns to RUN with no residual stall.
- Control response has zero latency: a hazard input asserted in cycle N drives the outputs in cycle N. The state effect is visible from cycle N+1.
- A load-use stall lasts exactly 1 cycle: after it, the load has moved to MEM, so `ex_memread` drops.
- MDU occupancy, with `ex_mdu_start` first seen in cycle N:
  - cycles N..N+MDU_CYCLES−2 stall (MDU_CYCLES−1 stall cycles);
  - cycle N+MDU_CYCLES−1 advances.
- `halted` rises the cycle after `wb_halt` and falls the cycle after `go`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → `pc_en`=0, all `en`/`clr`=1. After release, all counters=0, `halted`=0, idle inputs give advance.
- **Load-use:** `ex_memread`=1, `ex_dst`=5, `id_R1_use`=1, `id_R1_pos`=5 → `pc_en`=0, `ifid_en`=0, `idex_clr`=1, `stall_cnt`=1. Repeat with `ex_dst`=0 → advance, `stall_cnt` unchanged.
- **Branch vs load-use:** `ex_branch_taken`=1 with the load-use condition also true → `pc_en`=1, `ifid_clr`=`idex_clr`=1, `flush_cnt`=1, `stall_cnt`=0.
- **MDU:** MDU_CYCLES=5, `ex_mdu_start` held → 4 cycles with `pc_en`=0 and `exmem_clr`=1, then 1 advance cycle. `stall_cnt`=4, state returns to RUN.
- **Halt and resume:** `wb_halt` pulse → all `en`=0 and `halted`=1 next cycle; `cycle_cnt` constant over 10 cycles. `go` pulse → `halted`=0 and advance resumes.
- **Halt in MDU / reset in MDU:** `wb_halt` during MDU stall 2 → HALT, and after `go` there are no remaining MDU stalls. Separately, `rst` during MDU → RUN with counters=0.
